// File: rtl/vadd_sequencer_pkg.sv
// rtl/vadd_sequencer_pkg.sv - Vector Machine defaults, sequencer state encoding and overflow helper
package vadd_sequencer_pkg;

    localparam int VM_WIDTH = 24;
    localparam int VM_VLEN  = 8;

    typedef enum logic [1:0] {
        VM_S_IDLE  = 2'd0,
        VM_S_ISSUE = 2'd1,
        VM_S_DRAIN = 2'd2,
        VM_S_DONE  = 2'd3
    } vm_state_e;

    // Two's-complement overflow: like-signed operands produce a sum of the other sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/vadd_sequencer_adder.sv
// rtl/vadd_sequencer_adder.sv - combinational WIDTH-bit adder, carry-out dropped
module vadd_sequencer_adder #(
    parameter int WIDTH = 24
) (
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    assign sum = a + b;

endmodule

// File: rtl/vadd_sequencer.sv
// rtl/vadd_sequencer.sv - element-wise vector add sequencer; optional sticky overflow via VADD_OVF_EN
module vadd_sequencer
    import vadd_sequencer_pkg::*;
#(
    parameter int WIDTH  = VM_WIDTH,
    parameter int VLEN   = VM_VLEN,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data_a,
    input  logic [WIDTH-1:0]  rd_data_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
`ifdef VADD_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [ADDR_W:0] VLEN_L = (ADDR_W+1)'(VLEN);

    vm_state_e         state;
    logic [ADDR_W-1:0] last_addr;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [WIDTH-1:0]  sum;
    logic [ADDR_W:0]   len_clamp;

    assign len_clamp = (len > VLEN_L) ? VLEN_L : len;

    vadd_sequencer_adder #(.WIDTH(WIDTH)) u_adder (
        .sum (sum),
        .a   (rd_data_a),
        .b   (rd_data_b)
    );

    // rd_addr doubles as the element counter; last_addr is the latched len-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= VM_S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            last_addr <= '0;
        end else begin
            case (state)
                VM_S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len_clamp == '0) begin
                            done  <= 1'b1;
                            state <= VM_S_DONE;
                        end else begin
                            rd_en     <= 1'b1;
                            rd_addr   <= '0;
                            last_addr <= ADDR_W'(len_clamp - 1'b1);
                            state     <= VM_S_ISSUE;
                        end
                    end
                end
                VM_S_ISSUE: begin
                    if (rd_addr == last_addr) begin
                        rd_en <= 1'b0;
                        state <= VM_S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                VM_S_DRAIN: begin
                    // Once stage 1 is empty the final write is on its way out this edge.
                    if (!s1_valid) begin
                        done  <= 1'b1;
                        state <= VM_S_DONE;
                    end
                end
                VM_S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= VM_S_IDLE;
                end
                default: state <= VM_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_addr  <= rd_addr;
            wr_en    <= s1_valid;
            wr_addr  <= s1_addr;
            if (s1_valid) begin
                wr_data <= sum;
            end
        end
    end

`ifdef VADD_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == VM_S_IDLE && start) begin
            ovf <= 1'b0;
        end else if (s1_valid &&
                     signed_ovf(rd_data_a[WIDTH-1], rd_data_b[WIDTH-1], sum[WIDTH-1])) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vadd_sequencer.sv
// tb/tb_vadd_sequencer.sv - scoreboard bench for vadd_sequencer; covers ovf when VADD_OVF_EN is defined
module tb_vadd_sequencer;

    localparam int WIDTH  = 24;
    localparam int VLEN   = 8;
    localparam int ADDR_W = 3;
    localparam int NCYC   = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WIDTH-1:0]  rd_data_a = '0;
    logic [WIDTH-1:0]  rd_data_b = '0;
    logic [WIDTH-1:0]  wr_data;
`ifdef VADD_OVF_EN
    logic              ovf;
`endif

    vadd_sequencer #(.WIDTH(WIDTH), .VLEN(VLEN), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef VADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Operand register file contents as seen by the bench
    logic [WIDTH-1:0] mem_a [VLEN];
    logic [WIDTH-1:0] mem_b [VLEN];

    logic              cap_en = 1'b0;
    logic [ADDR_W-1:0] cap_addr = '0;
    always @(negedge clk) begin
        cap_en   = rd_en;
        cap_addr = rd_addr;
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (cap_en) begin
            rd_data_a = mem_a[cap_addr];
            rd_data_b = mem_b[cap_addr];
        end else begin
            rd_data_a = WIDTH'($urandom);
            rd_data_b = WIDTH'($urandom);
        end
    end

    // Expected outputs, indexed by absolute cycle number
    logic              exp_busy    [NCYC];
    logic              exp_done    [NCYC];
    logic              exp_rd_en   [NCYC];
    logic [ADDR_W-1:0] exp_rd_addr [NCYC];
    logic              exp_wr_en   [NCYC];
    logic [ADDR_W-1:0] exp_wr_addr [NCYC];
    logic [WIDTH-1:0]  exp_wr_data [NCYC];
    logic              exp_ovf     [NCYC];
    int                busy_end = -1;

    task automatic clear_expect(input int from);
        for (int i = from; i < NCYC; i++) begin
            exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_rd_en[i] = 1'b0; exp_wr_en[i] = 1'b0;
            exp_rd_addr[i] = '0; exp_wr_addr[i] = '0; exp_wr_data[i] = '0; exp_ovf[i] = 1'b0;
        end
    endtask

    task automatic schedule(input int n, input int req_len);
        int l;
        logic ov;
        logic [WIDTH-1:0] s;
        l  = (req_len > VLEN) ? VLEN : req_len;
        ov = 1'b0;
        if (n + l + 4 >= NCYC) return;
        if (l == 0) begin
            exp_busy[n+1] = 1'b1;
            exp_done[n+1] = 1'b1;
            exp_ovf[n+1]  = 1'b0;
            busy_end      = n + 1;
        end else begin
            for (int i = 1; i <= l + 3; i++) exp_busy[n+i] = 1'b1;
            for (int i = 0; i < l; i++) begin
                s = WIDTH'(({1'b0, mem_a[i]} + {1'b0, mem_b[i]}) % (1 << WIDTH));
                exp_rd_en[n+1+i]   = 1'b1;
                exp_rd_addr[n+1+i] = ADDR_W'(i);
                exp_wr_en[n+3+i]   = 1'b1;
                exp_wr_addr[n+3+i] = ADDR_W'(i);
                exp_wr_data[n+3+i] = s;
                if (mem_a[i][WIDTH-1] == mem_b[i][WIDTH-1] && s[WIDTH-1] != mem_a[i][WIDTH-1]) ov = 1'b1;
            end
            exp_done[n+l+3] = 1'b1;
            exp_ovf[n+l+3]  = ov;
            busy_end        = n + l + 3;
        end
    endtask

    // Observation logs for literal checks
    int               wr_cyc_q [$];
    logic [ADDR_W-1:0] wr_adr_q [$];
    logic [WIDTH-1:0]  wr_dat_q [$];
    int               done_q   [$];
    logic             ovf_q    [$];
    int               rd_cnt = 0;

    task automatic clear_logs();
        wr_cyc_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
        done_q.delete(); ovf_q.delete(); rd_cnt = 0;
    endtask

    initial clear_expect(0);

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < NCYC) begin
            chk("busy", busy, exp_busy[c]);
            chk("done", done, exp_done[c]);
            chk("rd_en", rd_en, exp_rd_en[c]);
            chk("wr_en", wr_en, exp_wr_en[c]);
            if (exp_rd_en[c]) chk("rd_addr", rd_addr, exp_rd_addr[c]);
            if (exp_wr_en[c]) begin
                chk("wr_addr", wr_addr, exp_wr_addr[c]);
                chk("wr_data", wr_data, exp_wr_data[c]);
            end
`ifdef VADD_OVF_EN
            if (exp_done[c]) chk("ovf", ovf, exp_ovf[c]);
`endif
        end
        if (rd_en) rd_cnt++;
        if (wr_en) begin
            wr_cyc_q.push_back(c);
            wr_adr_q.push_back(wr_addr);
            wr_dat_q.push_back(wr_data);
        end
        if (done) begin
            done_q.push_back(c);
`ifdef VADD_OVF_EN
            ovf_q.push_back(ovf);
`endif
        end
        if (start && !rst && c > busy_end) schedule(c, int'(len));
    end

    task automatic run_op(input int l, input int wait_cyc, output int s0);
        @(posedge clk); #1;
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        s0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        len   = (ADDR_W+1)'($urandom);
        repeat (wait_cyc) @(posedge clk);
    endtask

    task automatic check_op(input string tag, input int s0, input int l);
        chk({tag, "_nwr"}, wr_dat_q.size(), l);
        chk({tag, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({tag, "_done_cyc"}, done_q[0] - s0, l + 3);
        for (int i = 0; i < l; i++) begin
            if (i < wr_cyc_q.size()) begin
                chk({tag, "_wr_cyc"}, wr_cyc_q[i] - s0, 3 + i);
                chk({tag, "_wr_adr"}, wr_adr_q[i], i);
            end
        end
    endtask

    logic [WIDTH-1:0] t1_a   [3] = '{24'hC01401, 24'hD01402, 24'hC01400};
    logic [WIDTH-1:0] t1_b   [3] = '{24'hC41403, 24'hD0140B, 24'hC4100B};
    logic [WIDTH-1:0] t1_exp [3] = '{24'h842804, 24'hA0280D, 24'h84240B};

    initial begin
        int s0;
        for (int i = 0; i < VLEN; i++) begin
            mem_a[i] = WIDTH'($urandom);
            mem_b[i] = WIDTH'($urandom);
        end
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
`ifdef VADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // 1: len=3 with hand-computed sums
        for (int i = 0; i < 3; i++) begin
            mem_a[i] = t1_a[i];
            mem_b[i] = t1_b[i];
        end
        clear_logs();
        run_op(3, 8, s0);
        check_op("t1", s0, 3);
        for (int i = 0; i < 3; i++)
            if (i < wr_dat_q.size()) chk("t1_wr_data", wr_dat_q[i], t1_exp[i]);

        // 2: len=0
        clear_logs();
        run_op(0, 4, s0);
        chk("t2_rd_cnt", rd_cnt, 0);
        chk("t2_nwr", wr_dat_q.size(), 0);
        chk("t2_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("t2_done_cyc", done_q[0] - s0, 1);

        // 3: full length and clamped length
        for (int i = 0; i < VLEN; i++) begin
            mem_a[i] = WIDTH'($urandom);
            mem_b[i] = WIDTH'($urandom);
        end
        clear_logs();
        run_op(8, 13, s0);
        check_op("t3_len8", s0, 8);
        clear_logs();
        run_op(9, 13, s0);
        check_op("t3_len9", s0, 8);
        clear_logs();
        run_op(15, 13, s0);
        check_op("t3_len15", s0, 8);

        // 4: start pulses during the op and on its done cycle are ignored
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; len = 4; s0 = cyc;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; len = 7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; len = 6;
        @(posedge clk); #1;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(posedge clk);
        check_op("t4", s0, 4);

        // 5: asynchronous reset mid-ISSUE, then a fresh op
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; len = 5; s0 = cyc;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        clear_expect(cyc);
        busy_end = cyc;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_wr_data", wr_data, 0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("t5_nwr_abandoned", wr_dat_q.size(), 0);
        chk("t5_ndone_abandoned", done_q.size(), 0);
        clear_logs();
        run_op(2, 7, s0);
        check_op("t5_fresh", s0, 2);

        // 6: signed overflow element, then a clean op
        mem_a[0] = 24'h7FFFFF;
        mem_b[0] = 24'h000001;
        clear_logs();
        run_op(1, 5, s0);
        check_op("t6", s0, 1);
        if (wr_dat_q.size() > 0) chk("t6_wr_data", wr_dat_q[0], 24'h800000);
`ifdef VADD_OVF_EN
        if (ovf_q.size() > 0) chk("t6_ovf_set", ovf_q[0], 1);
`endif
        mem_a[0] = '0;
        mem_b[0] = '0;
        clear_logs();
        run_op(1, 5, s0);
        if (wr_dat_q.size() > 0) chk("t6_zero_data", wr_dat_q[0], 0);
`ifdef VADD_OVF_EN
        if (ovf_q.size() > 0) chk("t6_ovf_clr", ovf_q[0], 0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
